// File: rtl/mm_pcpi_loader.sv
// Sequencer that turns a byte stream into custom-0 PCPI writes (A, B, bias, threshold),
// then optionally issues start, waits for completion (with timeout) and issues clear.
// Ports: clk/resetn (sync, active-low); in_data/in_valid/in_ready byte stream;
//        pcpi_valid/pcpi_insn/pcpi_ready/pcpi_wait coprocessor side; busy/done/err status.
module mm_pcpi_loader #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wait,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Counter only needs to hold 0..TIMEOUT_CYCLES-1; the last value triggers the timeout.
  localparam int              TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      OPC_CUSTOM0 = 7'b0001011;
  localparam logic [31:0]     INSN_START  = {1'b0, 16'h0000, 3'b111, 5'd0, OPC_CUSTOM0};
  localparam logic [31:0]     INSN_CLEAR  = {1'b0, 16'h0000, 3'b101, 5'd0, OPC_CUSTOM0};

  typedef enum logic [3:0] {
    S_IDLE, S_RX_LO, S_RX_HI, S_ISSUE_WR, S_RUN_START, S_GUARD, S_WAIT, S_CLEAR, S_DONE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_sel, w_sel_nxt;
  logic           r_run, w_run_nxt;
  logic [4:0]     r_addr, w_addr_nxt;
  logic [7:0]     r_lo, w_lo_nxt;
  logic [15:0]    r_val, w_val_nxt;
  logic [TW-1:0]  r_tmo, w_tmo_nxt;
  logic           r_err, w_err_nxt;
  logic           r_in_ready, r_pcpi_valid, r_busy, r_done;
  logic [31:0]    r_pcpi_insn;
  logic           w_valid_nxt;
  logic [31:0]    w_insn_nxt;
  logic           w_acc;
  logic [5:0]     w_first;
  logic [5:0]     w_adv;

  // Group index of an address: 0=A, 1=B, 2=bias, 3=threshold.
  function automatic logic [2:0] f_group(input logic [4:0] a);
    if (a < 5'd9)       return 3'd0;
    else if (a < 5'd18) return 3'd1;
    else if (a < 5'd27) return 3'd2;
    else                return 3'd3;
  endfunction

  function automatic logic f_last_in_group(input logic [4:0] a);
    return (a == 5'd8) || (a == 5'd17) || (a == 5'd26) || (a == 5'd27);
  endfunction

  // {found, start address} of the lowest selected group at or after from_grp.
  function automatic logic [5:0] f_first_sel(input logic [3:0] sel, input logic [2:0] from_grp);
    logic [5:0] res;
    res = 6'd0;
    if (from_grp <= 3'd3 && sel[3]) res = {1'b1, 5'd27};
    if (from_grp <= 3'd2 && sel[2]) res = {1'b1, 5'd18};
    if (from_grp <= 3'd1 && sel[1]) res = {1'b1, 5'd9};
    if (from_grp == 3'd0 && sel[0]) res = {1'b1, 5'd0};
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_run        <= 1'b0;
      r_addr       <= '0;
      r_lo         <= '0;
      r_val        <= '0;
      r_tmo        <= '0;
      r_err        <= 1'b0;
      r_in_ready   <= 1'b0;
      r_pcpi_valid <= 1'b0;
      r_pcpi_insn  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_run        <= w_run_nxt;
      r_addr       <= w_addr_nxt;
      r_lo         <= w_lo_nxt;
      r_val        <= w_val_nxt;
      r_tmo        <= w_tmo_nxt;
      r_err        <= w_err_nxt;
      // Outputs are registered from the next state so they line up with it.
      r_in_ready   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RX_LO) || (w_state_nxt == S_RX_HI);
      r_pcpi_valid <= w_valid_nxt;
      r_pcpi_insn  <= w_insn_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_run_nxt   = r_run;
    w_addr_nxt  = r_addr;
    w_lo_nxt    = r_lo;
    w_val_nxt   = r_val;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_acc       = in_valid & r_in_ready;
    w_first     = f_first_sel(in_data[3:0], 3'd0);
    // Next address: step within the group, else jump to the next selected group.
    if (!f_last_in_group(r_addr)) w_adv = {1'b1, r_addr + 5'd1};
    else                          w_adv = f_first_sel(r_sel, 3'(f_group(r_addr) + 3'd1));

    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_sel_nxt = in_data[3:0];
          w_run_nxt = in_data[7];
          w_err_nxt = 1'b0;
          if (w_first[5]) begin
            w_addr_nxt  = w_first[4:0];
            w_state_nxt = S_RX_LO;
          end else if (in_data[7]) begin
            w_state_nxt = S_RUN_START;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RX_LO: begin
        if (w_acc) begin
          w_lo_nxt    = in_data;
          w_state_nxt = S_RX_HI;
        end
      end
      S_RX_HI: begin
        if (w_acc) begin
          w_val_nxt   = {in_data, r_lo};
          w_state_nxt = S_ISSUE_WR;
        end
      end
      S_ISSUE_WR: begin
        if (pcpi_ready) begin
          if (w_adv[5]) begin
            w_addr_nxt  = w_adv[4:0];
            w_state_nxt = S_RX_LO;
          end else if (r_run) begin
            w_state_nxt = S_RUN_START;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN_START: w_state_nxt = S_GUARD;
      S_GUARD: begin
        // Ignores pcpi_ready so a stale ready from the start cycle is not taken as completion.
        w_tmo_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (pcpi_ready && !pcpi_wait) begin
          w_state_nxt = S_CLEAR;
        end else if (r_tmo == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_CLEAR;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_CLEAR: begin
        if (pcpi_ready) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_valid_nxt = 1'b0;
    w_insn_nxt  = '0;
    case (w_state_nxt)
      S_ISSUE_WR: begin
        w_valid_nxt = 1'b1;
        w_insn_nxt  = {1'b0, w_val_nxt, 3'b000, w_addr_nxt, OPC_CUSTOM0};
      end
      S_RUN_START: begin
        w_valid_nxt = 1'b1;
        w_insn_nxt  = INSN_START;
      end
      S_CLEAR: begin
        w_valid_nxt = 1'b1;
        w_insn_nxt  = INSN_CLEAR;
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_insn_nxt  = '0;
      end
    endcase
  end

  assign in_ready   = r_in_ready;
  assign pcpi_valid = r_pcpi_valid;
  assign pcpi_insn  = r_pcpi_insn;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_mm_pcpi_loader.sv
// Directed bench for mm_pcpi_loader: byte source, PCPI responder with stall/latency knobs,
// and a log of accepted instructions checked against hand-computed encodings.
// Clock 10 ns; inputs driven 1 ns after posedge, outputs sampled on negedge.
module tb_mm_pcpi_loader;

  logic        clk;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wait;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;

  mm_pcpi_loader #(.TIMEOUT_CYCLES(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_ready(pcpi_ready),
    .pcpi_wait (pcpi_wait),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder / monitor state.
  logic [31:0] acc_q[$];
  int          len_q[$];
  int          hold_err, zero_err, inr_err;
  int          done_cnt, wr_seen, cur_len, gap, stall_left, stall_idx, run_lat, run_cnt;
  bit          running, prev_hold;
  logic [31:0] prev_insn;
  logic        done_err;
  logic        rsp_rdy, rsp_wt;

  always @(negedge clk) begin
    if (resetn && prev_hold && (!pcpi_valid || pcpi_insn !== prev_insn)) hold_err++;
    if (!pcpi_valid && pcpi_insn !== 32'h0) zero_err++;
    if (pcpi_valid && in_ready) inr_err++;
    if (done) begin
      done_cnt++;
      done_err = err;
    end
    rsp_rdy = 1'b0;
    rsp_wt  = 1'b0;
    if (!resetn) begin
      running = 1'b0;
      cur_len = 0;
    end else if (pcpi_valid) begin
      if (pcpi_insn[14:12] == 3'b000) begin
        cur_len++;
        if (stall_left > 0 && wr_seen + 1 == stall_idx) begin
          stall_left--;
        end else begin
          rsp_rdy = 1'b1;
          wr_seen++;
          len_q.push_back(cur_len);
          cur_len = 0;
          acc_q.push_back(pcpi_insn);
        end
      end else if (pcpi_insn[14:12] == 3'b111) begin
        acc_q.push_back(pcpi_insn);
        running = 1'b1;
        run_cnt = 0;
        gap     = 0;
      end else begin
        rsp_rdy = 1'b1;
        running = 1'b0;
        acc_q.push_back(pcpi_insn);
      end
    end else if (running) begin
      rsp_rdy = (run_cnt >= run_lat);
      rsp_wt  = !rsp_rdy;
      run_cnt++;
      gap++;
    end
    prev_hold  = resetn && pcpi_valid && !rsp_rdy && (pcpi_insn[14:12] != 3'b111);
    prev_insn  = pcpi_insn;
    pcpi_ready = rsp_rdy;
    pcpi_wait  = rsp_wt;
  end

  task automatic clear_log();
    acc_q.delete();
    len_q.delete();
    done_cnt   = 0;
    done_err   = 1'b0;
    wr_seen    = 0;
    cur_len    = 0;
    gap        = 0;
    stall_left = 0;
    stall_idx  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_byte: in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s done: no pulse within %0d cycles, required 1 pulse", name, n);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset in_ready: got %b, required 0", in_ready); end
    if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL reset pcpi_valid: got %b, required 0", pcpi_valid); end
    if (pcpi_insn !== 32'h0) begin errors++; $display("FAIL reset pcpi_insn: got %h, required 0", pcpi_insn); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset done: got %b, required 0", done); end
    if (err !== 1'b0)        begin errors++; $display("FAIL reset err: got %b, required 0", err); end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready before first edge: got %b, required 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready after release: got %b, required 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_run();
    logic [31:0] exp;
    clear_log();
    run_lat = 8;
    send_byte(8'h8F);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full busy after header: got %b, required 1", busy); end
    for (int k = 1; k <= 28; k++) begin
      send_byte(8'(k));
      send_byte(8'h00);
    end
    wait_done("full");
    checks += 5;
    if (done_err !== 1'b0) begin errors++; $display("FAIL full err at done: got %b, required 0", done_err); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL full busy after done: got %b, required 0", busy); end
    if (done_cnt != 1)     begin errors++; $display("FAIL full done pulses: got %0d, required 1", done_cnt); end
    if (gap != 9)          begin errors++; $display("FAIL full guard+wait cycles: got %0d, required 9", gap); end
    if (acc_q.size() != 30) begin errors++; $display("FAIL full insn count: got %0d, required 30", acc_q.size()); end
    if (acc_q.size() == 30) begin
      for (int k = 1; k <= 28; k++) begin
        exp = {1'b0, 16'(k), 3'b000, 5'(k - 1), 7'b0001011};
        checks++;
        if (acc_q[k-1] !== exp) begin errors++; $display("FAIL full write %0d: got %h, required %h", k, acc_q[k-1], exp); end
      end
      checks += 4;
      if (acc_q[0] !== 32'h0000800B)  begin errors++; $display("FAIL full write 1 word: got %h, required 0000800b", acc_q[0]); end
      if (acc_q[27] !== 32'h000E0D8B) begin errors++; $display("FAIL full write 28 word: got %h, required 000e0d8b", acc_q[27]); end
      if (acc_q[28] !== 32'h0000700B) begin errors++; $display("FAIL full start: got %h, required 0000700b", acc_q[28]); end
      if (acc_q[29] !== 32'h0000500B) begin errors++; $display("FAIL full clear: got %h, required 0000500b", acc_q[29]); end
    end
  endtask

  task automatic test_group_a();
    logic [31:0] exp;
    clear_log();
    send_byte(8'h01);
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h34);
      send_byte(8'h12);
    end
    wait_done("groupA");
    checks++;
    if (acc_q.size() != 9) begin errors++; $display("FAIL groupA insn count: got %0d, required 9", acc_q.size()); end
    for (int i = 0; i < 9 && i < acc_q.size(); i++) begin
      exp = 32'h091A000B | (32'(i) << 7);
      checks++;
      if (acc_q[i] !== exp) begin errors++; $display("FAIL groupA write %0d: got %h, required %h", i, acc_q[i], exp); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    clear_log();
    stall_idx  = 3;
    stall_left = 5;
    send_byte(8'h04);
    for (int i = 0; i < 9; i++) begin
      send_byte(8'(i));
      send_byte(8'hA5);
    end
    wait_done("stall");
    checks++;
    if (len_q.size() != 9) begin errors++; $display("FAIL stall write count: got %0d, required 9", len_q.size()); end
    if (len_q.size() == 9) begin
      checks += 2;
      if (len_q[2] != 6) begin errors++; $display("FAIL stall held cycles: got %0d, required 6", len_q[2]); end
      if (len_q[0] != 1) begin errors++; $display("FAIL stall 1-cycle write: got %0d, required 1", len_q[0]); end
      for (int i = 0; i < 9; i++) begin
        exp = {1'b0, 8'hA5, 8'(i), 3'b000, 5'(18 + i), 7'b0001011};
        checks++;
        if (acc_q[i] !== exp) begin errors++; $display("FAIL stall write %0d: got %h, required %h", i, acc_q[i], exp); end
      end
    end
    checks += 2;
    if (hold_err != 0) begin errors++; $display("FAIL stall hold stability: got %0d violations, required 0", hold_err); end
    if (inr_err != 0)  begin errors++; $display("FAIL stall in_ready while valid: got %0d, required 0", inr_err); end
  endtask

  task automatic test_threshold();
    logic [31:0] w;
    logic [15:0] v;
    clear_log();
    run_lat = 3;
    send_byte(8'h88);
    send_byte(8'hBA);
    send_byte(8'hFF);
    wait_done("thresh");
    checks++;
    if (acc_q.size() != 3) begin errors++; $display("FAIL thresh insn count: got %0d, required 3", acc_q.size()); end
    if (acc_q.size() == 3) begin
      w = acc_q[0];
      v = w[30:15];
      checks += 4;
      if (w !== 32'h7FDD0D8B) begin errors++; $display("FAIL thresh write: got %h, required 7fdd0d8b", w); end
      if (v !== 16'hFFBA)     begin errors++; $display("FAIL thresh value: got %h, required ffba", v); end
      if (acc_q[1] !== 32'h0000700B) begin errors++; $display("FAIL thresh start: got %h, required 0000700b", acc_q[1]); end
      if (acc_q[2] !== 32'h0000500B) begin errors++; $display("FAIL thresh clear: got %h, required 0000500b", acc_q[2]); end
    end
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL thresh err: got %b, required 0", done_err); end
  endtask

  task automatic test_timeout();
    clear_log();
    run_lat = 100000;
    send_byte(8'h80);
    wait_done("timeout");
    checks += 5;
    if (done_err !== 1'b1) begin errors++; $display("FAIL timeout err at done: got %b, required 1", done_err); end
    if (err !== 1'b1)      begin errors++; $display("FAIL timeout err sticky: got %b, required 1", err); end
    if (gap != 33)         begin errors++; $display("FAIL timeout guard+wait cycles: got %0d, required 33", gap); end
    if (acc_q.size() != 2) begin errors++; $display("FAIL timeout insn count: got %0d, required 2", acc_q.size()); end
    if (acc_q.size() == 2 && acc_q[1] !== 32'h0000500B) begin errors++; $display("FAIL timeout clear: got %h, required 0000500b", acc_q[1]); end
    // An empty header still clears the sticky flag and finishes directly.
    clear_log();
    send_byte(8'h00);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL errclear err after header: got %b, required 0", err); end
    wait_done("errclear");
    checks += 2;
    if (acc_q.size() != 0) begin errors++; $display("FAIL errclear insn count: got %0d, required 0", acc_q.size()); end
    if (done_err !== 1'b0) begin errors++; $display("FAIL errclear err at done: got %b, required 0", done_err); end
  endtask

  task automatic test_timeout_edge();
    // Ready on the very last wait cycle wins over the timeout.
    clear_log();
    run_lat = 32;
    send_byte(8'h80);
    wait_done("edge32");
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL edge32 err: got %b, required 0", done_err); end
    clear_log();
    run_lat = 33;
    send_byte(8'h80);
    wait_done("edge33");
    checks++;
    if (done_err !== 1'b1) begin errors++; $display("FAIL edge33 err: got %b, required 1", done_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    clear_log();
    run_lat = 8;
    send_byte(8'h8F);
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k));
      send_byte(8'h00);
    end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL midreset in_ready: got %b, required 0", in_ready); end
    if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL midreset pcpi_valid: got %b, required 0", pcpi_valid); end
    if (pcpi_insn !== 32'h0) begin errors++; $display("FAIL midreset pcpi_insn: got %h, required 0", pcpi_insn); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL midreset busy: got %b, required 0", busy); end
    if (err !== 1'b0)        begin errors++; $display("FAIL midreset err: got %b, required 0", err); end
    if (done_cnt != 0)       begin errors++; $display("FAIL midreset done pulses: got %0d, required 0", done_cnt); end
    @(posedge clk);
    #1 resetn = 1'b1;
    clear_log();
    send_byte(8'h02);
    for (int i = 0; i < 9; i++) begin
      send_byte(8'(16 * i + 3));
      send_byte(8'h02);
    end
    wait_done("midreset");
    checks++;
    if (acc_q.size() != 9) begin errors++; $display("FAIL midreset insn count: got %0d, required 9", acc_q.size()); end
    for (int i = 0; i < 9 && i < acc_q.size(); i++) begin
      exp = {1'b0, 8'h02, 8'(16 * i + 3), 3'b000, 5'(9 + i), 7'b0001011};
      checks++;
      if (acc_q[i] !== exp) begin errors++; $display("FAIL midreset write %0d: got %h, required %h", i, acc_q[i], exp); end
    end
  endtask

  task automatic test_invariants();
    checks += 3;
    if (hold_err != 0) begin errors++; $display("FAIL inv hold stability: got %0d violations, required 0", hold_err); end
    if (zero_err != 0) begin errors++; $display("FAIL inv insn zero when idle: got %0d violations, required 0", zero_err); end
    if (inr_err != 0)  begin errors++; $display("FAIL inv in_ready with pcpi_valid: got %0d violations, required 0", inr_err); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    hold_err   = 0;
    zero_err   = 0;
    inr_err    = 0;
    running    = 1'b0;
    prev_hold  = 1'b0;
    prev_insn  = '0;
    run_lat    = 8;
    run_cnt    = 0;
    resetn     = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    clear_log();
    test_reset();
    test_full_run();
    test_group_a();
    test_stall();
    test_threshold();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_pcpi_loader.md
# mm_pcpi_loader

Upstream sequencer for the fused 3x3 matrix-multiply PCPI coprocessor. It receives a byte stream from the narrow chip input port, assembles 16-bit operands and issues the custom-0 write instructions that fill A, B, bias and threshold. It can then issue the start instruction, wait for completion and issue the clear instruction. On silicon it replaces the CPU as PCPI master, so the coprocessor is usable from pins alone.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32: maximum cycles to wait for completion after start before flagging an error.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- pcpi_valid  out  1  instruction valid to coprocessor
- pcpi_insn  out  32  instruction word
- pcpi_ready  in  1  coprocessor ready
- pcpi_wait  in  1  coprocessor busy
- busy  out  1  frame in progress (not IDLE)
- done  out  1  one-cycle pulse, frame complete
- err  out  1  sticky completion-timeout flag

## Operation
- Frame: a header byte, then operand bytes, each 16-bit value sent low byte first.
- Header bits:
  - bit0: load A, 9 values, addresses 0-8.
  - bit1: load B, 9 values, addresses 9-17.
  - bit2: load bias, 9 values, addresses 18-26.
  - bit3: load threshold, 1 value, address 27.
  - bit7: run after load.
  - bits 6:4 ignored.
- Groups are sent in order A, B, bias, threshold, skipping unselected groups. Elements within a group are row-major.
- Instruction formats (bit 31 is always 0):
  - Write: {1'b0, value[15:0], 3'b000, addr[4:0], 7'b0001011}.
  - Start: funct3=111, addr=0, value=0.
  - Clear: funct3=101, addr=0, value=0.
- States:
  - IDLE: in_ready=1. A header byte moves to RX_LO if any group is selected, else to RUN_START if bit7=1, else to DONE. Accepting a header clears err.
  - RX_LO: in_ready=1. A byte is latched as low byte, then RX_HI.
  - RX_HI: in_ready=1. A byte is latched as high byte, then ISSUE_WR.
  - ISSUE_WR: in_ready=0. Drives pcpi_valid=1 with the write insn. Leaves when pcpi_ready=1 is sampled:
    - address advances to the next selected address;
    - if values remain, go to RX_LO;
    - else if bit7=1, go to RUN_START;
    - else go to DONE.
  - RUN_START: start insn with pcpi_valid=1 for exactly one cycle, then GUARD.
  - GUARD: one cycle, pcpi_valid=0, pcpi_ready ignored. Clears the timeout counter. Then WAIT.
  - WAIT: pcpi_valid=0, timeout counter increments each cycle.
    - pcpi_ready=1 and pcpi_wait=0 go to CLEAR.
    - If the counter reaches TIMEOUT_CYCLES, set err and go to CLEAR.
  - CLEAR: drives the clear insn with pcpi_valid=1 until pcpi_ready=1 is sampled, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- pcpi_insn is 0 whenever pcpi_valid=0.
- While pcpi_valid=1 and pcpi_ready=0, pcpi_insn and pcpi_valid are held stable.
- Bytes are consumed only on in_valid & in_ready. There is no byte buffering.

## Timing
- Reset: all outputs registered 0, state IDLE, counters cleared.
  - in_ready rises the first cycle after resetn=1.
  - Reset mid-frame drops the frame, deasserts pcpi_valid and clears err; no clear insn is issued.
- Write latency: pcpi_valid rises the cycle after the high byte is accepted.
  - A write completes in 1 cycle when pcpi_ready is already 1.
  - Minimum per value: 3 cycles (RX_LO, RX_HI, ISSUE_WR).
- Full frame with run: header + 56 bytes + 28 writes + start + guard + wait + clear + done.
- in_valid while in_ready=0 is ignored; the byte must be re-presented by the source.
- In WAIT, pcpi_ready=1 on the same cycle the counter reaches TIMEOUT_CYCLES counts as completion, not error.
- done and err are never both set by the same event, except err stays visible through DONE.
- Address counter is 5 bits and never exceeds 27.

## Test plan
- Header 0x8F, then 56 bytes with values 1..28: 28 writes in order.
  - Write k has addr=k-1, value=k, insn bits[6:0]=0001011, funct3=000.
  - Then start (funct3=111) for 1 cycle, wait ~9 cycles, clear, done pulse, err=0.
- Header 0x01, bytes 34 12 ×9: 9 writes of value 0x1234 to addr 0-8. No start; done follows the 9th write.
- Header 0x88, bytes BA FF (threshold -70): 1 write with addr=27, insn[30:15]=0xFFBA; then run completes.
- Model holds pcpi_ready=0 for 5 cycles on the 3rd write: pcpi_valid and pcpi_insn stable for all 6 cycles, in_ready=0 throughout.
- Model never completes after start: err=1 after TIMEOUT_CYCLES, then the clear insn is issued and done pulses. The next header clears err.
- resetn low after byte 10 of a 0x8F frame: outputs 0, busy=0. A new 0x02 frame writes addr 9-17 correctly.
